// File: rtl/dlatch_design.sv
// Dual gated D latch: a cross-coupled NAND latch (active-low data) and a
// cross-coupled NOR latch (active-high data), sharing one enable and one reset.
`timescale 1ns / 1ps

module dlatch_design (
    input  logic clk,
    input  logic rst,
    input  logic Nand_Dbar,
    output logic Nand_Q,
    output logic Nand_Qbar,
    input  logic Nor_D,
    output logic Nor_Q,
    output logic Nor_Qbar
);

    logic rst_n;
    logic nand_d;
    logic nand_s_n;
    logic nand_r_n;
    logic nand_q;
    logic nand_qbar;
    logic nor_s;
    logic nor_r;
    logic nor_q;
    logic nor_qbar;

    assign rst_n = ~rst;

    // NAND latch: reset blocks the set path and forces Qbar high, so Q settles
    // to 0 even while the enable is high with data 1.
    assign nand_d    = ~Nand_Dbar;
    assign nand_s_n  = ~(nand_d & clk & rst_n);
    assign nand_r_n  = ~(~nand_d & clk);
    assign nand_q    = ~(nand_s_n & nand_qbar);
    assign nand_qbar = ~(nand_r_n & nand_q & rst_n);

    // NOR latch: reset drives R and masks S, so S and R are never both active.
    assign nor_s    = Nor_D & clk & rst_n;
    assign nor_r    = (~Nor_D & clk) | rst;
    assign nor_q    = ~(nor_r | nor_qbar);
    assign nor_qbar = ~(nor_s | nor_q);

    assign Nand_Q    = nand_q;
    assign Nand_Qbar = nand_qbar;
    assign Nor_Q     = nor_q;
    assign Nor_Qbar  = nor_qbar;

endmodule

// File: tb/tb_dlatch_design.sv
// Scoreboard bench for dlatch_design: expected {Nand_Q, Nand_Qbar, Nor_Q, Nor_Qbar}
// is queued when stimulus is applied and compared once the outputs settle.
`timescale 1ns / 1ps

module tb_dlatch_design;

    logic clk;
    logic rst;
    logic Nand_Dbar;
    logic Nor_D;
    logic Nand_Q;
    logic Nand_Qbar;
    logic Nor_Q;
    logic Nor_Qbar;

    typedef struct {
        string      tag;
        logic [3:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    dlatch_design dut (
        .clk       (clk),
        .rst       (rst),
        .Nand_Dbar (Nand_Dbar),
        .Nand_Q    (Nand_Q),
        .Nand_Qbar (Nand_Qbar),
        .Nor_D     (Nor_D),
        .Nor_Q     (Nor_Q),
        .Nor_Qbar  (Nor_Qbar)
    );

    localparam logic [3:0] RST_PAT = 4'b0101;

    function automatic logic [3:0] pat(input logic nq, input logic norq);
        return {nq, ~nq, norq, ~norq};
    endfunction

    task automatic check_out(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_total++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %b expected %b (Nand_Q Nand_Qbar Nor_Q Nor_Qbar)", tag, got, exp);
    endtask

    task automatic push_exp(input string tag, input logic [3:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            n_total++;
            $display("FAIL sb_empty: got no queued expectation, required one");
        end else begin
            e = sb.pop_front();
            check_out(e.tag, {Nand_Q, Nand_Qbar, Nor_Q, Nor_Qbar}, e.exp);
        end
    endtask

    initial begin
        logic d;
        logic st;

        // 1: reset with enable high and data that would otherwise set both latches
        rst = 1'b1; clk = 1'b1; Nand_Dbar = 1'b0; Nor_D = 1'b1;
        push_exp("reset_transparent", RST_PAT);
        #1 pop_check();

        // 2: transparent tracking
        #1 rst = 1'b0;
        push_exp("release_tracks", pat(1'b1, 1'b1));
        #1 pop_check();
        Nand_Dbar = 1'b0; Nor_D = 1'b0;
        push_exp("track_nand1_nor0", pat(1'b1, 1'b0));
        #10 pop_check();
        Nand_Dbar = 1'b1; Nor_D = 1'b1;
        push_exp("track_nand0_nor1", pat(1'b0, 1'b1));
        #10 pop_check();

        // 3: hold, data toggling is ignored while clk is low
        Nand_Dbar = 1'b0; Nor_D = 1'b1;
        push_exp("pre_hold", pat(1'b1, 1'b1));
        #5 pop_check();
        clk = 1'b0;
        push_exp("hold_capture", pat(1'b1, 1'b1));
        #5 pop_check();
        for (int i = 0; i < 4; i++) begin
            Nand_Dbar = ~Nand_Dbar; Nor_D = ~Nor_D;
            push_exp($sformatf("hold_toggle%0d", i), pat(1'b1, 1'b1));
            #1 pop_check();
            #4;
        end
        Nand_Dbar = 1'b1; Nor_D = 1'b0;
        push_exp("hold_new_data", pat(1'b1, 1'b1));
        #2 pop_check();
        clk = 1'b1;
        push_exp("reopen", pat(1'b0, 1'b0));
        #1 pop_check();

        // 4: async reset pulse during hold
        #2 Nand_Dbar = 1'b0; Nor_D = 1'b1;
        #2 clk = 1'b0;
        push_exp("hold_ones", pat(1'b1, 1'b1));
        #5 pop_check();
        rst = 1'b1;
        push_exp("rst_in_hold", RST_PAT);
        #1 pop_check();
        #2 rst = 1'b0;
        push_exp("rst_release_hold", RST_PAT);
        #1 pop_check();
        push_exp("rst_release_hold_later", RST_PAT);
        #4 pop_check();

        // 5: reset released while transparent
        rst = 1'b1;
        #2 clk = 1'b1;
        push_exp("rst_over_enable", RST_PAT);
        #1 pop_check();
        rst = 1'b0;
        push_exp("rst_release_transparent", pat(1'b1, 1'b1));
        #1 pop_check();

        // 6: equivalence sweep against a behavioural reference latch
        d  = 1'b1;
        st = 1'b1;
        for (int i = 0; i < 200; i++) begin
            #1 clk = 1'($urandom_range(0, 1));
            if (clk) st = d;
            #2 d = 1'($urandom_range(0, 1));
            Nor_D = d; Nand_Dbar = ~d;
            if (clk) st = d;
            push_exp($sformatf("sweep%0d", i), pat(st, st));
            #2 pop_check();
            if (Nand_Q !== Nor_Q) begin
                n_total++;
                $display("FAIL sweep_equiv%0d: got Nand_Q=%b Nor_Q=%b, required equal", i, Nand_Q, Nor_Q);
            end
        end

        if (sb.size() != 0) begin
            n_total++;
            $display("FAIL sb_leftover: got %0d entries, required 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
